// File: rtl/keyboard_pkg.sv
// Shared constants and scan-code (set 2) to ASCII lookup for the PS/2 keyboard decoder.
package keyboard_pkg;

   localparam logic [7:0] IDLE_CODE = 8'h31;
   localparam logic [7:0] SC_EXTEND = 8'hE0;
   localparam logic [7:0] SC_BREAK  = 8'hF0;

   typedef enum logic [1:0] {
      KB_NORMAL,
      KB_EXT,
      KB_BREAK,
      KB_EXT_BREAK
   } kb_state_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] code;
   } map_t;

   // The '1' key (8'h16) stays unmapped: its ASCII value equals the idle code.
   function automatic map_t scan_to_ascii(input logic [7:0] sc);
      map_t m;
      m.valid = 1'b1;
      m.code  = 8'h00;
      case (sc)
         8'h1C: m.code = 8'h41;
         8'h32: m.code = 8'h42;
         8'h21: m.code = 8'h43;
         8'h23: m.code = 8'h44;
         8'h24: m.code = 8'h45;
         8'h2B: m.code = 8'h46;
         8'h34: m.code = 8'h47;
         8'h33: m.code = 8'h48;
         8'h43: m.code = 8'h49;
         8'h3B: m.code = 8'h4A;
         8'h42: m.code = 8'h4B;
         8'h4B: m.code = 8'h4C;
         8'h3A: m.code = 8'h4D;
         8'h31: m.code = 8'h4E;
         8'h44: m.code = 8'h4F;
         8'h4D: m.code = 8'h50;
         8'h15: m.code = 8'h51;
         8'h2D: m.code = 8'h52;
         8'h1B: m.code = 8'h53;
         8'h2C: m.code = 8'h54;
         8'h3C: m.code = 8'h55;
         8'h2A: m.code = 8'h56;
         8'h1D: m.code = 8'h57;
         8'h22: m.code = 8'h58;
         8'h35: m.code = 8'h59;
         8'h1A: m.code = 8'h5A;
         8'h45: m.code = 8'h30;
         8'h1E: m.code = 8'h32;
         8'h26: m.code = 8'h33;
         8'h25: m.code = 8'h34;
         8'h2E: m.code = 8'h35;
         8'h36: m.code = 8'h36;
         8'h3D: m.code = 8'h37;
         8'h3E: m.code = 8'h38;
         8'h46: m.code = 8'h39;
         8'h5A: m.code = 8'h0D;
         8'h29: m.code = 8'h20;
         8'h76: m.code = 8'h1B;
         default: m.valid = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/keyboard_fsm_ps2_rx.sv
// PS/2 frame receiver: synchronizes the bus, shifts in 11-bit frames on ps2_clk falling
// edges, validates start/stop/odd parity and abandons stalled partial frames.
module ps2_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0]    clk_sync_q;
   logic [2:0]    dat_sync_q;
   logic          clk_prev_q;
   logic [3:0]    cnt_q, cnt_d;
   logic [10:0]   frame_q, frame_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          fall;
   logic [10:0]   shifted;

   assign fall    = clk_prev_q & ~clk_sync_q[2];
   assign shifted = {dat_sync_q[2], frame_q[10:1]};

   always_comb begin
      cnt_d   = cnt_q;
      frame_d = frame_q;
      tmo_d   = tmo_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      if (fall) begin
         frame_d = shifted;
         tmo_d   = '0;
         if (cnt_q == 4'd10) begin
            cnt_d = '0;
            // Frame is LSB first, so after 11 shifts the start bit sits in bit 0.
            if (!shifted[0] && shifted[10] && (^shifted[9:1])) begin
               byte_d  = shifted[8:1];
               valid_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else if (cnt_q != 4'd0) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            cnt_d = '0;
            tmo_d = '0;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
         cnt_q      <= '0;
         frame_q    <= '0;
         tmo_q      <= '0;
         byte_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[1:0], ps2_data_i};
         clk_prev_q <= clk_sync_q[2];
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         tmo_q      <= tmo_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
      end
   end

   assign byte_o       = byte_q;
   assign byte_valid_o = valid_q;

endmodule

// File: rtl/keyboard_fsm.sv
// PS/2 keyboard decoder: tracks make/break/extended prefixes and the held key, and
// presents the held key's ASCII code (or the idle code) on a registered output.
module keyboard_fsm #(
   parameter logic [7:0]  IDLE_CODE      = keyboard_pkg::IDLE_CODE,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic [7:0] ascii
);

   import keyboard_pkg::*;

   logic [7:0] rx_byte;
   logic       rx_valid;
   kb_state_e  state_q, state_d;
   logic [7:0] held_q, held_d;
   logic [7:0] ascii_q, ascii_d;
   map_t       map;

   ps2_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk_i       (clk),
      .reset_i     (reset),
      .ps2_clk_i   (ps2_clk),
      .ps2_data_i  (ps2_data),
      .byte_o      (rx_byte),
      .byte_valid_o(rx_valid)
   );

   assign map = scan_to_ascii(rx_byte);

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      ascii_d = ascii_q;
      if (rx_valid) begin
         case (state_q)
            KB_NORMAL: begin
               if (rx_byte == SC_EXTEND) begin
                  state_d = KB_EXT;
               end else if (rx_byte == SC_BREAK) begin
                  state_d = KB_BREAK;
               end else if (map.valid && (rx_byte != held_q)) begin
                  ascii_d = map.code;
                  held_d  = rx_byte;
               end
            end
            KB_EXT: begin
               state_d = (rx_byte == SC_BREAK) ? KB_EXT_BREAK : KB_NORMAL;
            end
            KB_BREAK: begin
               state_d = KB_NORMAL;
               if ((held_q != 8'h00) && (rx_byte == held_q)) begin
                  ascii_d = IDLE_CODE;
                  held_d  = '0;
               end
            end
            // Extended keys are never held, so an extended break only clears the prefixes.
            KB_EXT_BREAK: state_d = KB_NORMAL;
            default:      state_d = KB_NORMAL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= KB_NORMAL;
         held_q  <= '0;
         ascii_q <= IDLE_CODE;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         ascii_q <= ascii_d;
      end
   end

   assign ascii = ascii_q;

endmodule

// File: tb/tb_keyboard_fsm.sv
// Bench for keyboard_fsm: directed vector table, latency/timeout/reset sequences and
// randomized scan-code streams checked against a flag-based reference model.
module tb_keyboard_fsm;

   localparam int unsigned TMO  = 200;
   localparam logic [7:0]  IDLE = 8'h31;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk_drv;
   logic       ps2_data_drv;
   wire        ps2_clk_w;
   wire        ps2_data_w;
   logic [7:0] ascii;

   assign ps2_clk_w  = ps2_clk_drv;
   assign ps2_data_w = ps2_data_drv;

   keyboard_fsm #(
      .IDLE_CODE     (IDLE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ps2_clk (ps2_clk_w),
      .ps2_data(ps2_data_w),
      .ascii   (ascii)
   );

   always #10 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: ascii=%02h expected=%02h", name, act, exp);
      end
   endtask

   // Reference model: scan-code table built from key lists, plus break/extended flags.
   int         lut [256];
   logic [7:0] mapped [$];
   logic [7:0] m_ascii;
   int         m_held;
   bit         m_brk, m_ext;

   function automatic void build_lut();
      logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                  8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};
      logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};
      for (int i = 0; i < 256; i++) lut[i] = -1;
      for (int i = 0; i < 26; i++) lut[let_sc[i]] = 'h41 + i;
      for (int i = 0; i < 10; i++) if (i != 1) lut[dig_sc[i]] = 'h30 + i;
      lut[8'h5A] = 'h0D;
      lut[8'h29] = 'h20;
      lut[8'h76] = 'h1B;
      for (int i = 0; i < 256; i++) if (lut[i] >= 0) mapped.push_back(8'(i));
   endfunction

   function automatic void model_reset();
      m_ascii = IDLE;
      m_held  = -1;
      m_brk   = 1'b0;
      m_ext   = 1'b0;
   endfunction

   function automatic void model_apply(input logic [7:0] b);
      if (m_brk) begin
         if (!m_ext && int'(b) == m_held) begin
            m_ascii = IDLE;
            m_held  = -1;
         end
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1'b1;
         else            m_ext = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (lut[b] >= 0 && int'(b) != m_held) begin
         m_ascii = 8'(lut[b]);
         m_held  = int'(b);
      end
   endfunction

   // err: 0 good, 1 bad parity, 2 bad stop, 3 bad start
   function automatic logic [10:0] mk_frame(input logic [7:0] d, input int err);
      logic [10:0] f;
      f = {1'b1, ~^d, d, 1'b0};
      if (err == 1) f[9]  = ~f[9];
      if (err == 2) f[10] = 1'b0;
      if (err == 3) f[0]  = 1'b1;
      return f;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input logic [10:0] f, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         ps2_data_drv = f[i];
         tick(4);
         ps2_clk_drv = 1'b0;
         tick(4);
         ps2_clk_drv = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] code, input int err);
      send_bits(mk_frame(code, err), 0, 10);
      tick(4);
      if (err == 0) model_apply(code);
   endtask

   typedef struct {
      logic [7:0] code;
      int         err;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [$];

   initial begin
      #(5_000_000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] f;
      logic [7:0]  code;
      int          r, err;

      build_lut();
      model_reset();
      ps2_clk_drv  = 1'b1;
      ps2_data_drv = 1'b1;
      reset        = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      check("reset_ascii", ascii, IDLE);
      for (int i = 0; i < 4; i++) begin
         tick(25);
         check("idle_hold", ascii, IDLE);
      end

      // 11th falling edge driven by hand to pin the latency.
      f = mk_frame(8'h1C, 0);
      send_bits(f, 0, 9);
      ps2_data_drv = f[10];
      tick(4);
      ps2_clk_drv = 1'b0;
      tick(4);
      check("lat_before", ascii, IDLE);
      tick(1);
      check("lat_2cyc", ascii, 8'h41);
      ps2_clk_drv = 1'b1;
      tick(4);
      model_apply(8'h1C);

      vecs.push_back('{8'hF0, 0, 8'h41});
      vecs.push_back('{8'h1C, 0, 8'h31});
      vecs.push_back('{8'h1C, 0, 8'h41});
      vecs.push_back('{8'h1C, 0, 8'h41});
      vecs.push_back('{8'h1C, 0, 8'h41});
      vecs.push_back('{8'hF0, 0, 8'h41});
      vecs.push_back('{8'h32, 0, 8'h41});
      vecs.push_back('{8'h5A, 1, 8'h41});
      vecs.push_back('{8'h5A, 0, 8'h0D});
      vecs.push_back('{8'h1C, 2, 8'h0D});
      vecs.push_back('{8'h1C, 3, 8'h0D});
      vecs.push_back('{8'hE0, 0, 8'h0D});
      vecs.push_back('{8'h75, 0, 8'h0D});
      vecs.push_back('{8'h16, 0, 8'h0D});
      vecs.push_back('{8'h76, 0, 8'h1B});
      vecs.push_back('{8'h45, 0, 8'h30});
      vecs.push_back('{8'hF0, 0, 8'h30});
      vecs.push_back('{8'h76, 0, 8'h30});
      vecs.push_back('{8'hE0, 0, 8'h30});
      vecs.push_back('{8'hF0, 0, 8'h30});
      vecs.push_back('{8'h45, 0, 8'h30});
      vecs.push_back('{8'hF0, 0, 8'h30});
      vecs.push_back('{8'h45, 0, 8'h31});
      foreach (vecs[i]) begin
         send(vecs[i].code, vecs[i].err);
         check($sformatf("vec%0d", i), ascii, vecs[i].exp);
      end

      // Partial frame left to time out, then a clean frame.
      send_bits(mk_frame(8'h1C, 0), 0, 5);
      tick(TMO + 10);
      send(8'h29, 0);
      check("timeout_recover", ascii, 8'h20);

      // Reset in the middle of a frame.
      send_bits(mk_frame(8'h1C, 0), 0, 4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      model_reset();
      check("reset_midframe", ascii, IDLE);
      tick(10);
      send(8'h45, 0);
      check("after_reset", ascii, 8'h30);

      for (int n = 0; n < 160; n++) begin
         r = $urandom_range(0, 99);
         if (m_brk && m_held >= 0 && $urandom_range(0, 1) == 1) code = 8'(m_held);
         else if (r < 35) code = mapped[$urandom_range(0, mapped.size() - 1)];
         else if (r < 52) code = 8'hF0;
         else if (r < 62) code = 8'hE0;
         else if (r < 75 && m_held >= 0) code = 8'(m_held);
         else code = 8'($urandom_range(0, 255));
         err = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
         send(code, err);
         check($sformatf("rand%0d_%02h_e%0d", n, code, err), ascii, m_ascii);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keyboard_fsm.md
KEYBOARD_FSM -- requirements
Module: keyboard_fsm

Interface
REQ-001 Parameter IDLE_CODE, default 8'h31: value driven on ascii when no mapped key is held.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 Port clk, input, 1 bit: system clock (50 MHz); the only clock; all logic is synchronous to its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port ps2_clk, inout, 1 bit: PS/2 clock; never driven by the block (high-Z), sampled only.
REQ-006 Port ps2_data, inout, 1 bit: PS/2 data; never driven (high-Z), sampled only.
REQ-007 Port ascii, output, 8 bits: ASCII code of the currently held mapped key, or IDLE_CODE; registered.

Function
REQ-010 The block SHALL pass ps2_clk and ps2_data through a 3-flop synchronizer each, and detect ps2_clk falling edges on the synchronized signal.
REQ-011 On each detected falling edge, the block SHALL sample synchronized ps2_data into an 11-bit frame: start (0), 8 data bits LSB first, odd parity, stop (1).
REQ-012 A frame SHALL be accepted only if start=0, stop=1 and parity is odd over data+parity; otherwise it is discarded silently and decoding state is unchanged.
REQ-013 If TIMEOUT_CYCLES elapse with no falling edge while 1..10 bits are collected, the bit counter SHALL clear to 0.
REQ-014 An accepted byte SHALL be processed in the cycle after the 11th falling edge is detected; ascii SHALL update in the following cycle (2-cycle latency from synchronized edge).
REQ-015 Byte 8'hE0 SHALL set an extended flag; the next non-F0 byte SHALL be ignored and clear the flag (extended keys are unmapped).
REQ-016 Byte 8'hF0 SHALL set a break flag; the next byte is a break code and clears both flags.
REQ-017 A make code with a mapping SHALL load ascii with the mapped value and record the scan code as the held key.
REQ-018 A make code with no mapping SHALL leave ascii and the held key unchanged.
REQ-019 A repeated make code for the already held key (typematic repeat) SHALL leave ascii unchanged.
REQ-020 A break code equal to the held key SHALL set ascii to IDLE_CODE and clear the held key.
REQ-021 A break code for any other key SHALL leave ascii unchanged.
REQ-022 Mapping: A-Z scan codes to uppercase 8'h41-8'h5A; digits 0,2-9 to 8'h30,8'h32-8'h39; the '1' key (8'h16) is unmapped because it collides with IDLE_CODE.
REQ-023 Further mappings: Enter 8'h5A to 8'h0D; Space 8'h29 to 8'h20; Esc 8'h76 to 8'h1B.
REQ-024 All other scan codes SHALL be unmapped.

Reset
REQ-030 While reset is high at a clk edge, ascii SHALL become IDLE_CODE, and the bit counter, frame register, break/extended flags, held key and timeout counter SHALL clear to 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the next frame is decoded normally.

Structure
REQ-040 IDLE_CODE, the constants 8'hE0/8'hF0, and the scan-to-ASCII lookup function SHALL reside in a shared package keyboard_pkg.
REQ-041 The frame receiver (REQ-010 to REQ-014) SHALL be one sub-module, ps2_rx, with outputs byte[7:0] and a 1-cycle byte_valid strobe; keyboard_fsm holds the make/break/held-key state machine.

Verification
REQ-050 Reset, then idle bus -> ascii=8'h31 and stays there.
REQ-051 Send frame 8'h1C ('A' make) -> ascii=8'h41 two cycles after the synchronized 11th edge; send F0,1C -> ascii=8'h31.
REQ-052 Send 1C,1C,1C (repeat) then F0,32 (break of 'B', not held) -> ascii stays 8'h41.
REQ-053 Send 8'h5A with bad parity -> discarded, ascii unchanged; then a good 8'h5A -> ascii=8'h0D.
REQ-054 Send 6 bits, idle for TIMEOUT_CYCLES+10 cycles, then a full frame 8'h29 -> ascii=8'h20.
REQ-055 Send E0,75 (extended) and 8'h16 ('1') -> ascii unchanged; assert reset mid-frame -> ascii=8'h31 and the next frame 8'h45 gives ascii=8'h30.
